// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the streaming VGA timing generator.
package video_timing_pkg;

  localparam int UNDERFLOW_CNT_W = 16;
  localparam int COORD_W = 12;

  typedef struct packed {
    logic               hs;
    logic               vs;
    logic               act;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               sof;
    logic               starve;
  } timing_t;

  function automatic int htotal(int fp, int pulse, int bp, int disp);
    return fp + pulse + bp + disp;
  endfunction

  function automatic int vtotal(int fp, int pulse, int bp, int disp);
    return fp + pulse + bp + disp;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// N-stage register chain for any packed type; contents cleared to zero on reset.
module pipe_delay #(
  parameter type T = logic,
  parameter int  N = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  T     d_i,
  output T     q_o
);

  T stage_q [N];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/vga_timing_stream.sv
// Programmable VGA timing that pops pixels ahead of the active region and re-aligns
// sync/blank with the returned data; outputs lag stage-0 counters by RD_LATENCY+1 cycles.
module vga_timing_stream import video_timing_pkg::*; #(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int HFP        = 40,
  parameter int HPULSE     = 48,
  parameter int HBP        = 40,
  parameter int VFP        = 13,
  parameter int VPULSE     = 3,
  parameter int VBP        = 29,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int RD_LATENCY = 1,
  parameter int RGB_W      = 24
) (
  input  logic                         pixel_clk,
  input  logic                         pixel_rst,
  input  logic                         start,
  output logic                         fifo_read,
  input  logic [RGB_W-1:0]             fifo_rdata,
  input  logic                         fifo_empty,
  output logic                         video_hs,
  output logic                         video_vs,
  output logic                         video_blank,
  output logic [RGB_W-1:0]             video_rgb,
  output logic [$clog2(HDISP)-1:0]     x,
  output logic [$clog2(VDISP)-1:0]     y,
  output logic                         sof,
  output logic                         underflow,
  output logic [UNDERFLOW_CNT_W-1:0]   underflow_cnt
);

  localparam int HTOTAL = htotal(HFP, HPULSE, HBP, HDISP);
  localparam int VTOTAL = vtotal(VFP, VPULSE, VBP, VDISP);
  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;
  localparam int HCW    = $clog2(HTOTAL);
  localparam int VCW    = $clog2(VTOTAL);
  localparam int XW     = $clog2(HDISP);
  localparam int YW     = $clog2(VDISP);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                       state_q, state_d;
  logic [HCW-1:0]               h_cnt_q, h_cnt_d;
  logic [VCW-1:0]               v_cnt_q, v_cnt_d;
  logic                         frame_end, act0, stream_dly;
  timing_t                      t0, t_dly;
  logic                         hs_q, vs_q, blank_q, sof_q, uf_q;
  logic [RGB_W-1:0]             rgb_q;
  logic [XW-1:0]                x_q;
  logic [YW-1:0]                y_q;
  logic [UNDERFLOW_CNT_W-1:0]   uf_cnt_q;
  logic                         unused_coord_hi;

  assign frame_end = (h_cnt_q == HCW'(HTOTAL-1)) && (v_cnt_q == VCW'(VTOTAL-1));

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HCW'(HTOTAL-1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VCW'(VTOTAL-1)) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Arming and disarming only take effect on the last cycle of a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_end && start)  state_d = STREAM;
      STREAM:  if (frame_end && !start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  assign act0      = (h_cnt_q >= HCW'(HSTART)) && (v_cnt_q >= VCW'(VSTART));
  assign fifo_read = act0 && (state_q == STREAM);

  always_comb begin
    t0        = '0;
    t0.hs     = (h_cnt_q >= HCW'(HFP)) && (h_cnt_q < HCW'(HFP + HPULSE));
    t0.vs     = (v_cnt_q >= VCW'(VFP)) && (v_cnt_q < VCW'(VFP + VPULSE));
    t0.act    = act0;
    t0.sof    = act0 && (h_cnt_q == HCW'(HSTART)) && (v_cnt_q == VCW'(VSTART));
    t0.starve = fifo_empty && fifo_read;
    if (act0) begin
      t0.x = COORD_W'(h_cnt_q - HCW'(HSTART));
      t0.y = COORD_W'(v_cnt_q - VCW'(VSTART));
    end
  end

  pipe_delay #(.T(timing_t), .N(RD_LATENCY)) u_timing_dly (
    .clk_i (pixel_clk),
    .rst_i (pixel_rst),
    .d_i   (t0),
    .q_o   (t_dly)
  );

  // Stream state at issue time travels separately so IDLE frames keep full timing.
  pipe_delay #(.T(logic), .N(RD_LATENCY)) u_stream_dly (
    .clk_i (pixel_clk),
    .rst_i (pixel_rst),
    .d_i   (state_q == STREAM),
    .q_o   (stream_dly)
  );

  assign unused_coord_hi = ^{t_dly.x[COORD_W-1:XW], t_dly.y[COORD_W-1:YW]};

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      blank_q  <= 1'b0;
      rgb_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      sof_q    <= 1'b0;
      uf_q     <= 1'b0;
      uf_cnt_q <= '0;
    end else begin
      hs_q    <= t_dly.hs ? HS_POL : ~HS_POL;
      vs_q    <= t_dly.vs ? VS_POL : ~VS_POL;
      blank_q <= t_dly.act;
      rgb_q   <= (t_dly.act && stream_dly && !t_dly.starve) ? fifo_rdata : '0;
      x_q     <= t_dly.x[XW-1:0];
      y_q     <= t_dly.y[YW-1:0];
      sof_q   <= t_dly.sof;
      if (t_dly.starve) begin
        uf_q <= 1'b1;
        if (uf_cnt_q != '1) uf_cnt_q <= uf_cnt_q + 1'b1;
      end
    end
  end

  assign video_hs      = hs_q;
  assign video_vs      = vs_q;
  assign video_blank   = blank_q;
  assign video_rgb     = rgb_q;
  assign x             = x_q;
  assign y             = y_q;
  assign sof           = sof_q;
  assign underflow     = uf_q;
  assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_vga_timing_stream.sv
// Two configurations (active-low sync / latency 2, active-high sync / latency 4) driven
// by a frame-level scenario; expected outputs come from a per-tick arithmetic model.
module tb_vga_timing_stream;

  localparam int HD  = 8;
  localparam int VD  = 4;
  localparam int HFP = 2;
  localparam int HP  = 3;
  localparam int HBP = 1;
  localparam int VFP = 1;
  localparam int VP  = 1;
  localparam int VBP = 1;
  localparam int HT  = HFP + HP + HBP + HD;
  localparam int VT  = VFP + VP + VBP + VD;
  localparam int FT  = HT * VT;
  localparam int HS0 = HFP + HP + HBP;
  localparam int VS0 = VFP + VP + VBP;
  localparam int RST_T = 9 * FT + (VS0 + 1) * HT + HS0 + 3;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [23:0] rgb;
    logic [2:0]  x;
    logic [1:0]  y;
    logic        sof;
    logic        uf;
    logic [15:0] ucnt;
  } exp_t;

  typedef struct {
    logic rd;
    logic last;
    int   exp_pops;
  } rd_t;

  function automatic exp_t reset_exp(bit pol);
    exp_t e;
    e    = '0;
    e.hs = !pol;
    e.vs = !pol;
    return e;
  endfunction

  logic clk;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam bit POL = (g == 1);
    localparam int LAT = (g == 1) ? 4 : 2;

    logic        rst, start, fifo_read, fifo_empty, hs, vs, blank, sof, underflow;
    logic [23:0] fifo_rdata, rgb;
    logic [2:0]  x;
    logic [1:0]  y;
    logic [15:0] ucnt;
    logic        mon_en, chk_rst, done;
    exp_t        out_q[$];
    rd_t         rd_q[$];

    vga_timing_stream #(
      .HDISP(HD), .VDISP(VD), .HFP(HFP), .HPULSE(HP), .HBP(HBP),
      .VFP(VFP), .VPULSE(VP), .VBP(VBP), .HS_POL(POL), .VS_POL(POL),
      .RD_LATENCY(LAT), .RGB_W(24)
    ) dut (
      .pixel_clk     (clk),
      .pixel_rst     (rst),
      .start         (start),
      .fifo_read     (fifo_read),
      .fifo_rdata    (fifo_rdata),
      .fifo_empty    (fifo_empty),
      .video_hs      (hs),
      .video_vs      (vs),
      .video_blank   (blank),
      .video_rgb     (rgb),
      .x             (x),
      .y             (y),
      .sof           (sof),
      .underflow     (underflow),
      .underflow_cnt (ucnt)
    );

    // Monitor: compares whatever the DUT shows against the scoreboard queues.
    initial begin
      exp_t e, a, re;
      rd_t  r;
      int   pops;
      pops = 0;
      forever begin
        @(negedge clk);
        a  = {hs, vs, blank, rgb, x, y, sof, underflow, ucnt};
        re = reset_exp(POL);
        if (rst === 1'b1 && chk_rst === 1'b1) begin
          checks++;
          if (a !== re || fifo_read !== 1'b0) begin
            errors++;
            $display("FAIL cfg%0d reset_values @%0t: got %h fifo_read=%b, required %h fifo_read=0",
                     g, $time, a, fifo_read, re);
          end
          pops = 0;
        end else if (mon_en === 1'b1) begin
          if (out_q.size() > 0) begin
            e = out_q.pop_front();
            checks++;
            if (a !== e) begin
              errors++;
              $display("FAIL cfg%0d video_out @%0t: got hs=%b vs=%b blank=%b rgb=%0h x=%0d y=%0d sof=%b uf=%b cnt=%0d, required hs=%b vs=%b blank=%b rgb=%0h x=%0d y=%0d sof=%b uf=%b cnt=%0d",
                       g, $time, a.hs, a.vs, a.blank, a.rgb, a.x, a.y, a.sof, a.uf, a.ucnt,
                       e.hs, e.vs, e.blank, e.rgb, e.x, e.y, e.sof, e.uf, e.ucnt);
            end
          end
          if (rd_q.size() > 0) begin
            r = rd_q.pop_front();
            checks++;
            if (fifo_read !== r.rd) begin
              errors++;
              $display("FAIL cfg%0d fifo_read @%0t: got %b, required %b", g, $time, fifo_read, r.rd);
            end
            if (fifo_read === 1'b1) pops++;
            if (r.last) begin
              checks++;
              if (pops != r.exp_pops) begin
                errors++;
                $display("FAIL cfg%0d pops_per_frame @%0t: got %0d, required %0d", g, $time, pops, r.exp_pops);
              end
              pops = 0;
            end
          end
        end else begin
          pops = 0;
        end
      end
    end

    // Driver: scenario stimulus, FIFO model and expected-output model.
    initial begin
      bit          m_stream, m_uf, prev_pop, act, rd, starve;
      int          m_pop, m_cnt, fifo_cnt, p, h, v, fr, nticks;
      logic [23:0] dpipe [4];
      exp_t        e;
      rd_t         r;
      rst = 1'b0; start = 1'b0; fifo_empty = 1'b0; fifo_rdata = '0;
      mon_en = 1'b0; chk_rst = 1'b0; done = 1'b0;
      #1;
      rst = 1'b1; chk_rst = 1'b1;
      for (int ph = 0; ph < 2; ph++) begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; chk_rst = 1'b0;
        m_stream = 0; m_uf = 0; prev_pop = 0; m_pop = 0; m_cnt = 0; fifo_cnt = 0;
        for (int k = 0; k < 4; k++) dpipe[k] = '0;
        out_q.delete();
        rd_q.delete();
        for (int k = 0; k <= LAT; k++) out_q.push_back(reset_exp(POL));
        mon_en = 1'b1;
        nticks = (ph == 0) ? RST_T : 3 * FT + LAT + 2;
        for (int t = 0; t < nticks; t++) begin
          if (t != 0) begin
            @(posedge clk);
            #1;
          end
          fr = t / FT; p = t % FT; h = p % HT; v = p / HT;
          for (int k = 3; k > 0; k--) dpipe[k] = dpipe[k-1];
          dpipe[0] = prev_pop ? 24'(fifo_cnt) : (24'h800000 | 24'($urandom));
          if (prev_pop) fifo_cnt++;
          fifo_rdata = dpipe[LAT-1];

          if (ph == 0) begin
            case (fr)
              0:       start = (p >= FT / 2);
              1:       start = 1'b1;
              2:       start = (p < FT / 2);
              3:       start = (p > 10 && p < FT - 5);
              4:       start = (p >= FT - 3);
              9:       start = 1'b1;
              default: start = (fr == 8 && p == FT - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            if (fr == 2) fifo_empty = (v == VS0 + 2) && (h >= HS0 + 2) && (h < HS0 + 5);
            else         fifo_empty = (fr >= 5) && ($urandom_range(0, 7) == 0);
          end else begin
            start      = 1'b1;
            fifo_empty = ($urandom_range(0, 5) == 0);
          end

          act     = (h >= HS0) && (v >= VS0);
          rd      = act && m_stream;
          starve  = rd && fifo_empty;
          e.hs    = (h >= HFP && h < HFP + HP) ? POL : !POL;
          e.vs    = (v >= VFP && v < VFP + VP) ? POL : !POL;
          e.blank = act;
          e.rgb   = (rd && !starve) ? 24'(m_pop) : 24'd0;
          e.x     = act ? 3'(h - HS0) : 3'd0;
          e.y     = act ? 2'(v - VS0) : 2'd0;
          e.sof   = act && (h == HS0) && (v == VS0);
          if (rd && !starve) m_pop++;
          if (starve) begin
            m_uf = 1;
            if (m_cnt < 65535) m_cnt++;
          end
          e.uf   = m_uf;
          e.ucnt = 16'(m_cnt);
          out_q.push_back(e);
          r.rd       = rd;
          r.last     = (p == FT - 1);
          r.exp_pops = m_stream ? HD * VD : 0;
          rd_q.push_back(r);
          if (p == FT - 1) m_stream = start;
          prev_pop = (fifo_read === 1'b1) && !fifo_empty;
        end
        if (ph == 0) begin
          @(posedge clk);
          #1;
          rst = 1'b1; chk_rst = 1'b1; mon_en = 1'b0;
        end
      end
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      done   = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(cfg[0].done === 1'b1 && cfg[1].done === 1'b1); i++)
      @(posedge clk);
    if (!(cfg[0].done === 1'b1 && cfg[1].done === 1'b1)) begin
      $display("FAIL run_timeout: drivers not done after 20000 cycles, required done");
      $fatal(1, "run did not complete");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_stream.md
# vga_timing_stream

Parametrised, single-clock successor to the fixed 800x480 VGA controller. Generates programmable HS/VS/BLANK timing with selectable sync polarity, issues pixel read requests to an upstream pixel FIFO ahead of the active region, and re-aligns sync/blank with the returned pixel data through a delay line matched to the FIFO read latency. Starts streaming only on a frame boundary. Substitutes black and flags underflow when the FIFO cannot supply a requested pixel. Sits between the pixel-side read port of the async framebuffer FIFO and `video_if`.

## Interface
- `HDISP`, 800: active pixels per line
- `VDISP`, 480: active lines per frame
- `HFP`/`HPULSE`/`HBP`, 40/48/40: horizontal front porch, sync, back porch (pixels, each >=1)
- `VFP`/`VPULSE`/`VBP`, 13/3/29: vertical front porch, sync, back porch (lines, each >=1)
- `HS_POL`/`VS_POL`, 0/0: sync level during pulse; idle level is the inverse
- `RD_LATENCY`, 1: FIFO rdata valid this many cycles after `fifo_read` (1..4)
- `RGB_W`, 24: pixel width
- `pixel_clk  in  1`: pixel clock, the only clock
- `pixel_rst  in  1`: asynchronous, active-high reset
- `start  in  1`: level; arms streaming, sampled every cycle
- `fifo_read  out  1`: pop request to the pixel FIFO
- `fifo_rdata  in  RGB_W`: FIFO data, valid `RD_LATENCY` cycles after the pop
- `fifo_empty  in  1`: FIFO empty, sampled in the same cycle as the pop
- `video_ifm  video_if.master`: CLK=`pixel_clk`, HS, VS, BLANK (high = active pixel), RGB
- `x  out  $clog2(HDISP)`, `y  out  $clog2(VDISP)`: coordinates of the pixel on RGB, aligned with BLANK
- `sof  out  1`: one-cycle pulse with pixel (0,0) on RGB
- `underflow  out  1`: sticky; cleared only by reset
- `underflow_cnt  out  16`: saturating count of starved pixels

## Operation
- Line order: FP, PULSE, BP, ACTIVE. HTOTAL = HFP+HPULSE+HBP+HDISP. Same order for frames; VTOTAL defined the same way.
- Stage 0 counters:
  - `h_cnt` runs 0..HTOTAL-1 and wraps.
  - `v_cnt` increments when `h_cnt` wraps, and wraps at VTOTAL-1 on that same cycle only.
- Stage 0 decode:
  - hs0 = `h_cnt` in [HFP, HFP+HPULSE).
  - vs0 = `v_cnt` in [VFP, VFP+VPULSE).
  - act0 = `h_cnt` >= HFP+HPULSE+HBP and `v_cnt` >= VFP+VPULSE+VBP.
- Streaming state machine:
  - IDLE: `start`=1 at `h_cnt`=HTOTAL-1 and `v_cnt`=VTOTAL-1 -> STREAM.
  - STREAM: `start`=0 at the same frame boundary -> IDLE. Mid-frame deassertion is ignored until the frame boundary.
- `fifo_read` = act0 AND STREAM, combinational from registered state. It is issued even when `fifo_empty`=1; the FIFO ignores pops while empty.
- Per-request tag:
  - Tag bit = `fifo_empty` AND `fifo_read`.
  - The tag travels with hs0, vs0, act0, coordinates and first-pixel flag through a delay line of `RD_LATENCY` stages.
  - A final output register then drives video_ifm and `x`/`y`/`sof`.
- Output register:
  - RGB = `fifo_rdata` when delayed act AND STREAM-at-issue AND NOT tag; else 0.
  - IDLE frames output full timing with black RGB.
- Starved pixel (tag=1 at output): set `underflow`; increment `underflow_cnt`, saturating at 16'hFFFF.
- HS/VS driven as `HS_POL`/`VS_POL` when asserted, inverse otherwise.

## Timing
- Reset values: HS=~HS_POL, VS=~VS_POL, BLANK=0, RGB=0, `x`=`y`=0, `sof`=0, `fifo_read`=0, `underflow`=0, `underflow_cnt`=0. Counters are 0 and state is IDLE.
- Output latency from stage 0 = `RD_LATENCY`+1 cycles, identical for HS, VS, BLANK, RGB, `x`, `y`, `sof`.
- First pop occurs at stage 0 (h=HFP+HPULSE+HBP, v=VFP+VPULSE+VBP) of the first full frame after arming.
- Exactly HDISP*VDISP pops per STREAM frame; 0 pops in IDLE frames.
- Reset mid-frame: all outputs return to reset values asynchronously. Delay-line contents are discarded. Any FIFO flush is the upstream's responsibility.
- `start` pulse shorter than one frame that misses the boundary cycle: no effect.

## Structure
- Package `video_timing_pkg`:
  - `timing_t` struct (hs, vs, act, x, y, sof, starve).
  - Function `htotal`/`vtotal`.
  - Constant `UNDERFLOW_CNT_W`=16.
- Sub-module `pipe_delay #(type T, int N)`: N-stage register chain with async reset to '0. It carries `timing_t`.
- Estimated 200-300 lines RTL total.

## Test plan
- Small params: HDISP=8, VDISP=4, HFP=2, HPULSE=3, HBP=1, VFP=1, VPULSE=1, VBP=1, RD_LATENCY=2. Check HTOTAL=14 and VTOTAL=7. HS low for exactly 3 cycles, output at cycles 5..7 of each line. VS low for exactly 14 cycles.
- Same params, `start`=1 mid-frame: zero pops until the next frame boundary, then 32 pops per frame.
- Model FIFO returns pixel index: RGB at BLANK rise = 0 with `sof`=1, `x`=0, `y`=0. Last active pixel has RGB=31, `x`=7, `y`=3.
- `fifo_empty` forced for 3 pops on line 2: those 3 pixels are black, `underflow`=1, `underflow_cnt`=3; timing unchanged.
- Set HS_POL=1, VS_POL=1, RD_LATENCY=4: pulses are inverted and latency is 5 cycles. Drop `start` mid-frame: pops continue to end of frame, then none.
- Assert `pixel_rst` mid-line: all outputs are at reset values on the same cycle, with no `fifo_read`. Release: timing restarts from h=0, v=0.
